counter_ctrl: RTL and testbench

Sequencer for the P1 counter datapath. Drives the shared 4-bit adder's operands each cycle and commits its sum into the count register. Supports start/stop/load control, up/down stepping by a programmable step, and terminal detection against a programmable limit. It sits between the top-level control inputs and the adder; the adder itself stays purely combinational.

---
 rtl/counter_ctrl.sv | 121 ++++++++++++
 tb/tb_counter_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer for the P1 counter datapath.
// Presents count/step/dir to the shared combinational adder and commits the
// sum into the count register, clamping to the programmed limit.
// Optional feature macro: COUNTER_CTRL_AUTORELOAD_EN (reload from load_val
// after each terminal and keep counting).
//
// state | meaning
// IDLE  | waiting for start, count held
// RUN   | one count update per cycle through the external adder
// DONE  | terminal reached, count == limit, done pulses for this cycle
module counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             err_nxt;
  logic             terminal;

  // Terminal when the step would cross/reach limit or leave the WIDTH range.
  // Down mode uses A + ~B + 1, so carry-out low means a borrow.
  always_comb begin
    terminal = 1'b0;
    if (dir) begin
      terminal = !add_cout || (add_sum <= limit);
    end else begin
      terminal = add_cout || (add_sum >= limit);
    end
  end

  // Next-state and next-count decode; load beats stop beats start.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = 1'b0;
    if (load) begin
      count_nxt = load_val;
      state_nxt = IDLE;
    end else if (stop && (state == RUN)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // stop outranks start, so a simultaneous stop suppresses the start
          if (start && !stop) begin
            if (step == '0) begin
              err_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (terminal) begin
            count_nxt = limit;
            state_nxt = DONE;
          end else begin
            count_nxt = add_sum;
          end
        end
        DONE: begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
          count_nxt = load_val;
          state_nxt = RUN;
`else
          state_nxt = IDLE;
`endif
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, count and error-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  assign add_a   = count;
  assign add_b   = step;
  assign add_sub = dir;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: directed scenarios plus randomized control
// traffic, checked every cycle against an arithmetic reference model.
// Honours COUNTER_CTRL_AUTORELOAD_EN the same way the design does.
module tb_counter_ctrl;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] step = '0;
  logic [W-1:0] limit = '0;
  logic         dir = 1'b0;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_sub;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .step(step), .limit(limit), .dir(dir),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_sum(add_sum), .add_cout(add_cout),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  // The shared adder the controller drives.
  logic [W:0] full;
  always_comb begin
    full = '0;
    if (add_sub) full = {1'b0, add_a} + {1'b0, ~add_b} + 5'd1;
    else         full = {1'b0, add_a} + {1'b0, add_b};
  end
  assign add_sum  = full[W-1:0];
  assign add_cout = full[W];

  // Reference model: mode 0 idle, 1 counting, 2 terminal cycle.
  int m_cnt = 0;
  int m_mode = 0;
  bit m_err = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int nxt;
    bit term;
    bit e;
    e = 1'b0;
    if (!rst_n) begin
      m_cnt = 0;
      m_mode = 0;
      m_valid = 1'b1;
    end else if (load) begin
      m_cnt = int'(load_val);
      m_mode = 0;
    end else if (stop && m_mode == 1) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (start && !stop) begin
        if (step == 0) e = 1'b1;
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      nxt = dir ? m_cnt - int'(step) : m_cnt + int'(step);
      term = dir ? (nxt < 0 || nxt <= int'(limit))
                 : (nxt > MAXV || nxt >= int'(limit));
      if (term) begin
        m_cnt = int'(limit);
        m_mode = 2;
      end else begin
        m_cnt = nxt;
      end
    end else begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
      m_cnt = int'(load_val);
      m_mode = 1;
`else
      m_mode = 0;
`endif
    end
    m_err = e;
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("count", int'(count), m_cnt);
      cmp("busy", int'(busy), (m_mode == 1) ? 1 : 0);
      cmp("done", int'(done), (m_mode == 2) ? 1 : 0);
      cmp("err", int'(err), int'(m_err));
      cmp("add_a", int'(add_a), m_cnt);
      cmp("add_b", int'(add_b), int'(step));
      cmp("add_sub", int'(add_sub), int'(dir));
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Literal expectation checked on both the DUT and the model.
  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    cmp({name, "_dut"}, dut_v, exp);
    cmp({name, "_model"}, mdl_v, exp);
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_val = W'(v);
    cyc();
    load = 1'b0;
  endtask

  task automatic go(input int s, input int l, input bit d);
    step = W'(s);
    limit = W'(l);
    dir = d;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // reset held two cycles
    rst_n = 1'b0;
    step = 4'd6;
    cyc();
    cyc();
    lit("rst_count", int'(count), m_cnt, 0);
    lit("rst_busy", int'(busy), m_mode, 0);
    cmp("rst_done", int'(done), 0);
    cmp("rst_err", int'(err), 0);
    cmp("rst_add_b", int'(add_b), 6);
    rst_n = 1'b1;
    cyc();

    // up count 2,5,8,11
    do_load(2);
    go(3, 11, 1'b0);
    lit("up_c2", int'(count), m_cnt, 2);
    cyc(); lit("up_c5", int'(count), m_cnt, 5);
    cyc(); lit("up_c8", int'(count), m_cnt, 8);
    cyc(); lit("up_c11", int'(count), m_cnt, 11);
    cmp("up_done", int'(done), 1);
    cyc();
    cmp("up_done_once", int'(done), 0);
`ifndef COUNTER_CTRL_AUTORELOAD_EN
    lit("up_idle_hold", int'(count), m_cnt, 11);
    cmp("up_idle_busy", int'(busy), 0);
`endif
    do_load(0);

    // down with borrow clamp
    do_load(5);
    go(4, 0, 1'b1);
    cyc(); lit("dn_c1", int'(count), m_cnt, 1);
    cyc(); lit("dn_c0", int'(count), m_cnt, 0);
    cmp("dn_done", int'(done), 1);
    do_load(0);

    // overflow clamp
    do_load(14);
    go(3, 15, 1'b0);
    cyc(); lit("ovf_c15", int'(count), m_cnt, 15);
    cmp("ovf_done", int'(done), 1);
    do_load(0);

    // zero step start rejected
    go(0, 9, 1'b0);
    lit("err_pulse", int'(err), int'(m_err), 1);
    cmp("err_busy", int'(busy), 0);
    cyc();
    cmp("err_once", int'(err), 0);

    // stop mid-run holds count
    do_load(2);
    go(3, 14, 1'b0);
    cyc(); lit("stop_c5", int'(count), m_cnt, 5);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    lit("stop_hold", int'(count), m_cnt, 5);
    cmp("stop_busy", int'(busy), 0);

    // load coincident with terminal
    do_load(2);
    go(3, 11, 1'b0);
    cyc(); cyc();
    lit("ldt_c8", int'(count), m_cnt, 8);
    load = 1'b1;
    load_val = 4'd7;
    cyc();
    load = 1'b0;
    lit("ldt_c7", int'(count), m_cnt, 7);
    cmp("ldt_nodone", int'(done), 0);
    cmp("ldt_busy", int'(busy), 0);

`ifdef COUNTER_CTRL_AUTORELOAD_EN
    // reload sequence 0,4,8,0,4,8
    do_load(0);
    go(4, 8, 1'b0);
    for (int r = 0; r < 2; r++) begin
      lit("ar_c0", int'(count), m_cnt, 0);
      cyc(); lit("ar_c4", int'(count), m_cnt, 4);
      cyc(); lit("ar_c8", int'(count), m_cnt, 8);
      cmp("ar_done", int'(done), 1);
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cmp("ar_stopped", int'(busy), 0);
`endif

    // randomized control traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(299) != 0);
      load     = ($urandom_range(24) == 0);
      stop     = ($urandom_range(19) == 0);
      start    = ($urandom_range(2) == 0);
      load_val = W'($urandom_range(MAXV));
      if ($urandom_range(3) == 0) begin
        step  = ($urandom_range(5) == 0) ? '0 : W'($urandom_range(MAXV, 1));
        limit = W'($urandom_range(MAXV));
        dir   = 1'($urandom_range(1));
      end
      cyc();
    end
    rst_n = 1'b1;
    load = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
